// File: rtl/mac_r_fetch.sv
// mac_r_fetch: pops frame descriptors from the normal and time-triggered
// receive queues, drains each frame's bytes and presents them as a
// ready/valid byte stream with sof/eof framing. TTE frames win at frame
// boundaries; bad, oversize and zero-length frames are dropped and counted.
module mac_r_fetch #(
    parameter int LEN_W   = 12,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             ptr_fifo_rd,
    input  logic [15:0]      ptr_fifo_dout,
    input  logic             ptr_fifo_empty,
    output logic             data_fifo_rd,
    input  logic [7:0]       data_fifo_dout,
    output logic             tteptr_fifo_rd,
    input  logic [15:0]      tteptr_fifo_dout,
    input  logic             tteptr_fifo_empty,
    output logic             tte_fifo_rd,
    input  logic [7:0]       tte_fifo_dout,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_tte,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PTR_WAIT = 2'd1;
    localparam logic [1:0] S_XFER     = 2'd2;
    localparam logic [1:0] S_DROP     = 2'd3;

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    logic [1:0]       state;
    logic             run;          // low for the first cycle after reset release
    logic             sel;          // 1: TTE queue owns the current frame
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] issued;       // data reads issued for the current frame

    // One data read can be in flight; its byte appears on dout a cycle later.
    logic             inflight;
    logic             inflight_sof;
    logic             inflight_eof;

    // Two-entry skid buffer, entry 0 is the head; each entry is {byte, sof, eof}.
    logic [9:0]       skid0;
    logic [9:0]       skid1;
    logic [1:0]       skid_cnt;

    logic [15:0]      desc;
    logic [LEN_W-1:0] desc_len;
    logic             desc_bad;
    logic             pop;
    logic             push;
    logic [1:0]       occ_next;
    logic             xfer_rd;
    logic             drop_rd;
    logic             data_rd;
    logic             last_drop;
    logic [7:0]       rd_byte;
    logic [9:0]       push_entry;
    logic             unused_desc_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Descriptor decode for whichever queue was popped in IDLE.
    assign desc     = sel ? tteptr_fifo_dout : ptr_fifo_dout;
    assign desc_len = desc[LEN_W-1:0];
    assign desc_bad = desc[15] || (desc_len > MAX_LEN_V);

    // Reserved descriptor bits carry no meaning here.
    assign unused_desc_bits = ^desc[14:LEN_W];

    // Stream handshake: out_valid comes straight from a register.
    assign out_valid = (skid_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = inflight;
    assign out_data  = skid0[9:2];
    assign out_sof   = skid0[1];
    assign out_eof   = skid0[0];
    assign out_tte   = sel;

    // Issue a read only if its byte is sure to find a free skid slot; a
    // same-cycle pop frees one, which is what sustains one byte per clock.
    assign occ_next  = skid_cnt + {1'b0, inflight} - {1'b0, pop};
    assign xfer_rd   = (state == S_XFER) && (issued < len_r) && (occ_next < 2'd2);
    assign drop_rd   = (state == S_DROP) && (issued < len_r);
    assign data_rd   = xfer_rd || drop_rd;
    assign last_drop = drop_rd && (issued == len_r - 1'b1);

    assign data_fifo_rd   = data_rd && !sel;
    assign tte_fifo_rd    = data_rd && sel;
    assign tteptr_fifo_rd = (state == S_IDLE) && run && !tteptr_fifo_empty;
    assign ptr_fifo_rd    = (state == S_IDLE) && run && tteptr_fifo_empty && !ptr_fifo_empty;

    assign rd_byte    = sel ? tte_fifo_dout : data_fifo_dout;
    assign push_entry = {rd_byte, inflight_sof, inflight_eof};

    // Frame-level FSM: arbitration, descriptor latch, read counting, statistics.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            run      <= 1'b0;
            sel      <= 1'b0;
            len_r    <= '0;
            issued   <= '0;
            good_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            // NOTE: non-blocking so every branch below sees this cycle's values.
            run <= 1'b1;
            if (data_rd) begin
                issued <= issued + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (tteptr_fifo_rd) begin
                        sel   <= 1'b1;
                        state <= S_PTR_WAIT;
                    end else if (ptr_fifo_rd) begin
                        sel   <= 1'b0;
                        state <= S_PTR_WAIT;
                    end
                end
                S_PTR_WAIT: begin
                    len_r  <= desc_len;
                    issued <= '0;
                    if (desc_len == '0) begin
                        drop_cnt <= sat_inc(drop_cnt);
                        state    <= S_IDLE;
                    end else if (desc_bad) begin
                        state <= S_DROP;
                    end else begin
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (pop && out_eof) begin
                        good_cnt <= sat_inc(good_cnt);
                        state    <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (last_drop) begin
                        drop_cnt <= sat_inc(drop_cnt);
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag each issued read with its framing so the byte lands already marked.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight     <= 1'b0;
            inflight_sof <= 1'b0;
            inflight_eof <= 1'b0;
        end else begin
            inflight     <= xfer_rd;
            inflight_sof <= (issued == '0);
            inflight_eof <= (issued == len_r - 1'b1);
        end
    end

    // Skid buffer: absorbs returning bytes while downstream stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: entries are reset because the head drives output ports directly.
            skid0    <= '0;
            skid1    <= '0;
            skid_cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) begin
                        skid0 <= push_entry;
                    end else begin
                        skid1 <= push_entry;
                    end
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid0 <= push_entry;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_r_fetch.sv
// Bench for mac_r_fetch: queue-based FIFO models feed the DUT, a frame-level
// model predicts the byte stream and counters, and one negedge process
// compares every accepted beat and every stall against it.
module tb_mac_r_fetch;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       tte;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ptr_fifo_rd;
    logic [15:0] ptr_fifo_dout = '0;
    logic        ptr_fifo_empty = 1'b1;
    logic        data_fifo_rd;
    logic [7:0]  data_fifo_dout = '0;
    logic        tteptr_fifo_rd;
    logic [15:0] tteptr_fifo_dout = '0;
    logic        tteptr_fifo_empty = 1'b1;
    logic        tte_fifo_rd;
    logic [7:0]  tte_fifo_dout = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sof;
    logic        out_eof;
    logic        out_tte;
    logic [15:0] good_cnt;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    mac_r_fetch dut (
        .clk              (clk),
        .rstn             (rstn),
        .ptr_fifo_rd      (ptr_fifo_rd),
        .ptr_fifo_dout    (ptr_fifo_dout),
        .ptr_fifo_empty   (ptr_fifo_empty),
        .data_fifo_rd     (data_fifo_rd),
        .data_fifo_dout   (data_fifo_dout),
        .tteptr_fifo_rd   (tteptr_fifo_rd),
        .tteptr_fifo_dout (tteptr_fifo_dout),
        .tteptr_fifo_empty(tteptr_fifo_empty),
        .tte_fifo_rd      (tte_fifo_rd),
        .tte_fifo_dout    (tte_fifo_dout),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sof          (out_sof),
        .out_eof          (out_eof),
        .out_tte          (out_tte),
        .good_cnt         (good_cnt),
        .drop_cnt         (drop_cnt)
    );

    // Upstream queue contents and the predicted stream.
    logic [15:0] ptr_q[$];
    logic [15:0] tteptr_q[$];
    logic [7:0]  data_q[$];
    logic [7:0]  tte_q[$];
    logic [15:0] bn_q[$];
    logic [15:0] bt_q[$];
    beat_t       exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int m_good = 0;
    int m_drop = 0;
    int m_nrd = 0;
    int m_trd = 0;
    int base_nrd = 0;
    int base_trd = 0;
    int nrd_cnt = 0;
    int trd_cnt = 0;
    int underflow = 0;
    int cyc = 0;
    int sof_cyc = 0;
    int eof_cyc = 0;
    int mode = 0;
    int ph = 0;
    bit got_first = 1'b0;
    logic first_tte = 1'b0;
    logic stall_prev = 1'b0;
    beat_t prev_beat = '0;
    beat_t cur_beat;
    beat_t e;

    assign cur_beat = {out_data, out_sof, out_eof, out_tte};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // FIFO models: one-cycle read latency, empty flags follow the queues.
    always @(posedge clk) begin
        if (ptr_fifo_rd) begin
            if (ptr_q.size() == 0) underflow++;
            else ptr_fifo_dout <= ptr_q.pop_front();
        end
        if (tteptr_fifo_rd) begin
            if (tteptr_q.size() == 0) underflow++;
            else tteptr_fifo_dout <= tteptr_q.pop_front();
        end
        if (data_fifo_rd) begin
            nrd_cnt++;
            if (data_q.size() == 0) underflow++;
            else data_fifo_dout <= data_q.pop_front();
        end
        if (tte_fifo_rd) begin
            trd_cnt++;
            if (tte_q.size() == 0) underflow++;
            else tte_fifo_dout <= tte_q.pop_front();
        end
        ptr_fifo_empty    <= (ptr_q.size() == 0);
        tteptr_fifo_empty <= (tteptr_q.size() == 0);
    end

    // Compare process: drives out_ready, checks stalls and accepted beats.
    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            stall_prev = 1'b0;
            out_ready  = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_beat", 32'(cur_beat), 32'(prev_beat));
            end
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (ph % 4 == 0) || (ph % 4 == 3);
                    ph++;
                end
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_beat: got 0x%0h, want no beat", cur_beat);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'(cur_beat), 32'(e));
                end
                if (out_sof) begin
                    sof_cyc = cyc;
                    if (!got_first) begin
                        got_first = 1'b1;
                        first_tte = out_tte;
                    end
                end
                if (out_eof) eof_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            prev_beat  = cur_beat;
        end
    end

    task automatic add_desc(input bit tte, input logic [15:0] d);
        if (tte) bt_q.push_back(d);
        else bn_q.push_back(d);
    endtask

    // Frame model: every descriptor's bytes are popped; only good frames are seen.
    task automatic emit_frame(input bit tte, input logic [15:0] d);
        int len;
        bit good;
        logic [7:0] b;
        len  = int'(d[11:0]);
        good = (len != 0) && !d[15] && (len <= 1518);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if (tte) tte_q.push_back(b);
            else data_q.push_back(b);
            if (good) exp_q.push_back('{data: b, sof: (i == 0), eof: (i == len - 1), tte: tte});
        end
        if (tte) begin
            tteptr_q.push_back(d);
            m_trd += len;
        end else begin
            ptr_q.push_back(d);
            m_nrd += len;
        end
        if (good) m_good++;
        else m_drop++;
    endtask

    // Pushed together while idle, all TTE frames precede all normal frames.
    task automatic commit_batch();
        foreach (bt_q[i]) emit_frame(1'b1, bt_q[i]);
        foreach (bn_q[i]) emit_frame(1'b0, bn_q[i]);
        bt_q.delete();
        bn_q.delete();
    endtask

    task automatic start_scn();
        base_nrd  = nrd_cnt;
        base_trd  = trd_cnt;
        m_nrd     = 0;
        m_trd     = 0;
        got_first = 1'b0;
    endtask

    task automatic wait_exp_below(input int n, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() < n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL progress_timeout: got %0d pending beats, want < %0d", exp_q.size(), n);
        end
    endtask

    task automatic finish_scn(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && ptr_q.size() == 0 && tteptr_q.size() == 0 &&
                data_q.size() == 0 && tte_q.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d beats and %0d bytes left, want 0", exp_q.size(),
                     data_q.size() + tte_q.size());
        end
        repeat (4) @(negedge clk);
        check("good_cnt", good_cnt, m_good);
        check("drop_cnt", drop_cnt, m_drop);
        check("data_rd", nrd_cnt - base_nrd, m_nrd);
        check("tte_rd", trd_cnt - base_trd, m_trd);
        check("underflow", underflow, 0);
    endtask

    function automatic logic [15:0] rand_desc();
        logic [15:0] d;
        int r;
        d        = 16'($urandom_range(1, 150));
        d[14:12] = 3'($urandom);
        r        = $urandom_range(0, 9);
        if (r == 0) d[11:0] = '0;
        if (r == 1) d[15] = 1'b1;
        return d;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_framing"}, 32'({out_sof, out_eof, out_tte}), 32'd0);
        check({tag, "_good"}, 32'(good_cnt), 32'd0);
        check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
        check({tag, "_rd"}, 32'({ptr_fifo_rd, tteptr_fifo_rd, data_fifo_rd, tte_fifo_rd}), 32'd0);
    endtask

    initial begin
        int nt;
        int nn;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        #1 rstn = 1'b1;

        // 64-byte normal frame, downstream always ready: back-to-back beats.
        mode = 0;
        start_scn();
        add_desc(1'b0, 16'h0040);
        commit_batch();
        finish_scn(2000);
        check("span64", eof_cyc - sof_cyc, 63);
        check("good_lit1", good_cnt, 1);
        check("first_tte0", 32'(first_tte), 32'd0);

        // 100-byte frame with ready pattern 1,0,0,1.
        mode = 1;
        ph   = 0;
        start_scn();
        add_desc(1'b0, 16'h0064);
        commit_batch();
        finish_scn(3000);
        check("rd100", nrd_cnt - base_nrd, 100);
        check("good_lit2", good_cnt, 2);

        // Bad 100-byte frame drained silently, then a good 60-byte frame.
        mode = 0;
        start_scn();
        add_desc(1'b0, 16'h8064);
        add_desc(1'b0, 16'h003C);
        commit_batch();
        finish_scn(3000);
        check("rd160", nrd_cnt - base_nrd, 160);
        check("drop_lit1", drop_cnt, 1);
        check("good_lit3", good_cnt, 3);

        // Both queues loaded while idle: TTE frame goes first.
        mode = 2;
        start_scn();
        add_desc(1'b0, 16'h0014);
        add_desc(1'b1, 16'h001E);
        commit_batch();
        finish_scn(3000);
        check("first_tte1", 32'(first_tte), 32'd1);
        check("good_lit5", good_cnt, 5);

        // TTE descriptor arriving mid-way through a 1514-byte frame waits for its eof.
        mode = 0;
        start_scn();
        add_desc(1'b0, 16'h05EA);
        commit_batch();
        wait_exp_below(1000, 3000);
        add_desc(1'b1, 16'h0028);
        commit_batch();
        finish_scn(5000);
        check("first_tte_mid", 32'(first_tte), 32'd0);
        check("good_lit7", good_cnt, 7);

        // Zero-length and oversize (2047) descriptors.
        start_scn();
        add_desc(1'b0, 16'h0000);
        add_desc(1'b0, 16'h07FF);
        commit_batch();
        finish_scn(5000);
        check("rd2047", nrd_cnt - base_nrd, 2047);
        check("drop_lit3", drop_cnt, 3);

        // Randomised batches across both queues and all ready modes.
        for (int b = 0; b < 6; b++) begin
            mode = $urandom_range(0, 2);
            start_scn();
            nt = $urandom_range(0, 3);
            nn = $urandom_range(1, 4);
            for (int i = 0; i < nt; i++) add_desc(1'b1, rand_desc());
            for (int i = 0; i < nn; i++) add_desc(1'b0, rand_desc());
            commit_batch();
            finish_scn(20000);
        end

        // One-cycle reset mid-frame, then a fresh frame.
        mode = 0;
        start_scn();
        add_desc(1'b0, 16'h00C8);
        commit_batch();
        wait_exp_below(150, 2000);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_idle_outputs("midreset");
        ptr_q.delete();
        tteptr_q.delete();
        data_q.delete();
        tte_q.delete();
        exp_q.delete();
        m_good = 0;
        m_drop = 0;
        @(negedge clk);
        #2 rstn = 1'b1;
        start_scn();
        add_desc(1'b0, 16'h001E);
        commit_batch();
        finish_scn(2000);
        check("good_after_reset", good_cnt, 1);
        check("drop_after_reset", drop_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
